// File: rtl/stress_pkg.sv
// Shared types for the stress trend monitor: per-channel trend codes,
// combine-mode constants and the channel FSM state.
package stress_pkg;

    typedef enum logic [1:0] {
        TrendNone   = 2'b00,
        TrendLower  = 2'b01,
        TrendEqual  = 2'b10,
        TrendHigher = 2'b11
    } trend_t;

    localparam logic MODE_ANY = 1'b0;
    localparam logic MODE_ALL = 1'b1;

    typedef enum logic {
        ChEmpty,
        ChPrimed
    } chan_state_t;

endpackage

// File: rtl/stress_trend_chan.sv
// One sensor channel: window accumulator, sample counter, reference register
// and the hysteresis comparator that classifies each closed window.
module stress_trend_chan
    import stress_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned LOG2_WIN = 2,
    parameter int unsigned TOL      = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         eval_tick,
    input  logic         smp_valid,
    input  logic [W-1:0] smp_data,
    output trend_t       trend,
    output logic         primed
);

    localparam int unsigned AW = W + LOG2_WIN;
    localparam logic [LOG2_WIN:0] WIN_CNT = (LOG2_WIN + 1)'(1 << LOG2_WIN);
    localparam logic [LOG2_WIN:0] CNT_ONE = (LOG2_WIN + 1)'(1);
    localparam logic [W:0]        TOL_EXT = (W + 1)'(TOL);

    logic [AW-1:0]     acc_q, acc_d;
    logic [LOG2_WIN:0] cnt_q, cnt_d;
    logic [W-1:0]      prev_q, prev_d;
    trend_t            trend_q, trend_d;
    chan_state_t       state_q, state_d;

    logic          full;
    logic [W-1:0]  cur;
    logic [W:0]    cur_ext, prev_ext;
    logic [AW-1:0] smp_ext;

    assign full     = (cnt_q == WIN_CNT);
    assign cur      = acc_q[AW-1:LOG2_WIN];
    // One extra bit so adding the tolerance can never wrap.
    assign cur_ext  = {1'b0, cur};
    assign prev_ext = {1'b0, prev_q};
    assign smp_ext  = {{LOG2_WIN{1'b0}}, smp_data};

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        trend_d = trend_q;
        state_d = state_q;
        if (eval_tick) begin
            trend_d = TrendNone;
            if (full) begin
                if (state_q == ChPrimed) begin
                    if (cur_ext + TOL_EXT < prev_ext) begin
                        trend_d = TrendLower;
                    end else if (cur_ext > prev_ext + TOL_EXT) begin
                        trend_d = TrendHigher;
                    end else begin
                        trend_d = TrendEqual;
                    end
                end
                prev_d  = cur;
                state_d = ChPrimed;
            end
            // A coincident sample opens the next window.
            acc_d = smp_valid ? smp_ext : '0;
            cnt_d = smp_valid ? CNT_ONE : '0;
        end else if (smp_valid && !full) begin
            acc_d = acc_q + smp_ext;
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
            trend_q <= TrendNone;
            state_q <= ChEmpty;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            trend_q <= trend_d;
            state_q <= state_d;
        end
    end

    assign trend  = trend_q;
    assign primed = (state_q == ChPrimed);

endmodule

// File: rtl/stress_trend.sv
// Multi-channel stress trend monitor: per-channel window trends combined in
// ANY/ALL mode into decreased/unchanged/increased flags one cycle later.
module stress_trend
    import stress_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned W        = 8,
    parameter int unsigned LOG2_WIN = 2,
    parameter int unsigned TOL      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             eval_tick,
    input  logic [NCH-1:0]   smp_valid,
    input  logic [NCH*W-1:0] smp_data,
    input  logic [NCH-1:0]   ch_enable,
    input  logic             mode,
    output logic [2*NCH-1:0] trend,
    output logic             gedaald,
    output logic             gelijk,
    output logic             gestegen,
    output logic             res_valid,
    output logic             primed
);

    trend_t         ch_trend [NCH];
    logic [NCH-1:0] ch_primed;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        stress_trend_chan #(
            .W        (W),
            .LOG2_WIN (LOG2_WIN),
            .TOL      (TOL)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .eval_tick (eval_tick),
            .smp_valid (smp_valid[c]),
            .smp_data  (smp_data[c*W +: W]),
            .trend     (ch_trend[c]),
            .primed    (ch_primed[c])
        );
        assign trend[2*c +: 2] = ch_trend[c];
    end

    logic [NCH-1:0] part, hit_lo, hit_eq, hit_hi;
    logic           dec_d, eq_d, inc_d;
    logic           eval_d1_q, dec_q, eq_q, inc_q, res_valid_q;

    always_comb begin
        part   = '0;
        hit_lo = '0;
        hit_eq = '0;
        hit_hi = '0;
        for (int c = 0; c < NCH; c++) begin
            part[c]   = ch_enable[c] && (ch_trend[c] != TrendNone);
            hit_lo[c] = (ch_trend[c] == TrendLower);
            hit_eq[c] = (ch_trend[c] == TrendEqual);
            hit_hi[c] = (ch_trend[c] == TrendHigher);
        end
        if (mode == MODE_ALL) begin
            dec_d = (|part) && ((hit_lo & part) == part);
            eq_d  = (|part) && ((hit_eq & part) == part);
            inc_d = (|part) && ((hit_hi & part) == part);
        end else begin
            dec_d = |(hit_lo & part);
            eq_d  = |(hit_eq & part);
            inc_d = |(hit_hi & part);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            eval_d1_q   <= 1'b0;
            res_valid_q <= 1'b0;
            dec_q       <= 1'b0;
            eq_q        <= 1'b0;
            inc_q       <= 1'b0;
        end else begin
            eval_d1_q   <= eval_tick;
            res_valid_q <= eval_d1_q;
            // Flags hold between results.
            if (eval_d1_q) begin
                dec_q <= dec_d;
                eq_q  <= eq_d;
                inc_q <= inc_d;
            end
        end
    end

    assign gedaald   = dec_q;
    assign gelijk    = eq_q;
    assign gestegen  = inc_q;
    assign res_valid = res_valid_q;
    assign primed    = (|ch_enable) && ((ch_primed & ch_enable) == ch_enable);

endmodule

// File: tb/tb_stress_trend.sv
// Bench for stress_trend: directed scenarios followed by random traffic, all
// checked every cycle against a window/average reference model.
module tb_stress_trend;

    localparam int NCH      = 2;
    localparam int W        = 8;
    localparam int LOG2_WIN = 2;
    localparam int TOL      = 2;
    localparam int WIN      = 1 << LOG2_WIN;

    logic             clk = 1'b0;
    logic             reset;
    logic             eval_tick;
    logic [NCH-1:0]   smp_valid;
    logic [NCH*W-1:0] smp_data;
    logic [NCH-1:0]   ch_enable;
    logic             mode;
    logic [2*NCH-1:0] trend;
    logic             gedaald, gelijk, gestegen, res_valid, primed;

    stress_trend #(
        .NCH      (NCH),
        .W        (W),
        .LOG2_WIN (LOG2_WIN),
        .TOL      (TOL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .eval_tick (eval_tick),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .ch_enable (ch_enable),
        .mode      (mode),
        .trend     (trend),
        .gedaald   (gedaald),
        .gelijk    (gelijk),
        .gestegen  (gestegen),
        .res_valid (res_valid),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: window sum/count, reference average, trend code 0..3.
    int msum [NCH];
    int mn   [NCH];
    int mprev[NCH];
    int mhave[NCH];
    int mtr  [NCH];
    int mlo, meq, mhi, mrv, evp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NCH*W-1:0] pack(input int a, input int b);
        logic [W-1:0] x, y;
        x = W'(a);
        y = W'(b);
        return {y, x};
    endfunction

    task automatic model_edge();
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                msum[c] = 0; mn[c] = 0; mprev[c] = 0; mhave[c] = 0; mtr[c] = 0;
            end
            mlo = 0; meq = 0; mhi = 0; mrv = 0; evp = 0;
        end else begin
            mrv = evp;
            if (evp != 0) begin
                int npart;
                int hits[4];
                npart = 0;
                hits  = '{default: 0};
                for (int c = 0; c < NCH; c++) begin
                    if (ch_enable[c] && mtr[c] != 0) begin
                        npart++;
                        hits[mtr[c]]++;
                    end
                end
                if (mode) begin
                    mlo = int'(npart > 0 && hits[1] == npart);
                    meq = int'(npart > 0 && hits[2] == npart);
                    mhi = int'(npart > 0 && hits[3] == npart);
                end else begin
                    mlo = int'(hits[1] > 0);
                    meq = int'(hits[2] > 0);
                    mhi = int'(hits[3] > 0);
                end
            end
            for (int c = 0; c < NCH; c++) begin
                int sample;
                sample = int'(smp_data[c*W +: W]);
                if (eval_tick) begin
                    if (mn[c] == WIN) begin
                        int avg;
                        avg = msum[c] / WIN;
                        if (mhave[c] == 0)           mtr[c] = 0;
                        else if (avg + TOL < mprev[c]) mtr[c] = 1;
                        else if (avg > mprev[c] + TOL) mtr[c] = 3;
                        else                           mtr[c] = 2;
                        mprev[c] = avg;
                        mhave[c] = 1;
                    end else begin
                        mtr[c] = 0;
                    end
                    msum[c] = smp_valid[c] ? sample : 0;
                    mn[c]   = smp_valid[c] ? 1 : 0;
                end else if (smp_valid[c] && mn[c] < WIN) begin
                    msum[c] += sample;
                    mn[c]++;
                end
            end
            evp = int'(eval_tick);
        end
    endtask

    task automatic compare_all();
        int all_primed;
        all_primed = (ch_enable != 0) ? 1 : 0;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("trend%0d", c), 32'(trend[2*c +: 2]), 32'(mtr[c]));
            if (ch_enable[c] && mhave[c] == 0) all_primed = 0;
        end
        check("gedaald", 32'(gedaald), 32'(mlo));
        check("gelijk", 32'(gelijk), 32'(meq));
        check("gestegen", 32'(gestegen), 32'(mhi));
        check("res_valid", 32'(res_valid), 32'(mrv));
        check("primed", 32'(primed), 32'(all_primed));
    endtask

    task automatic cyc(input logic ev, input logic [NCH-1:0] v, input logic [NCH*W-1:0] d);
        eval_tick = ev;
        smp_valid = v;
        smp_data  = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic feed(input int a, input int b, input logic [NCH-1:0] v, input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, v, pack(a, b));
    endtask

    task automatic tick();
        cyc(1'b1, '0, '0);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0);
    endtask

    int base[NCH];

    initial begin
        reset = 1'b0; eval_tick = 1'b0; smp_valid = '0; smp_data = '0;
        ch_enable = 2'b11; mode = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            msum[c] = 0; mn[c] = 0; mprev[c] = 0; mhave[c] = 0; mtr[c] = 0;
        end
        mlo = 0; meq = 0; mhi = 0; mrv = 0; evp = 0;

        // 1: reset held while strobing, then first window gives NONE
        for (int i = 0; i < 3; i++) cyc(i[0], 2'b11, pack(200, 200));
        check("rst_outputs", 32'({trend, gedaald, gelijk, gestegen, res_valid, primed}), 32'd0);
        reset = 1'b1;
        feed(50, 0, 2'b01, 4);
        tick();
        check("first_none", 32'(trend[1:0]), 32'd0);

        // 2: 100 then 90 gives LOWER, flags at t+2
        feed(100, 0, 2'b01, 4); tick();
        feed(90, 0, 2'b01, 4);  tick();
        check("t2_lower", 32'(trend[1:0]), 32'd1);
        check("t2_ch1_none", 32'(trend[3:2]), 32'd0);
        idle();
        check("t2_gedaald", 32'(gedaald), 32'd1);
        check("t2_res_valid", 32'(res_valid), 32'd1);

        // 3: hysteresis edges and a dropped fifth sample
        feed(100, 0, 2'b01, 4); tick();
        feed(102, 0, 2'b01, 4); tick();
        check("t3_equal", 32'(trend[1:0]), 32'd2);
        feed(100, 0, 2'b01, 4); tick();
        feed(103, 0, 2'b01, 4);
        feed(255, 0, 2'b01, 1); tick();
        check("t3_higher", 32'(trend[1:0]), 32'd3);

        // 4: short window keeps the old reference
        feed(50, 0, 2'b01, 3); tick();
        check("t4_short_none", 32'(trend[1:0]), 32'd0);
        feed(80, 0, 2'b01, 4); tick();
        check("t4_lower", 32'(trend[1:0]), 32'd1);

        // 5: ANY vs ALL combine, channel masking
        feed(200, 60, 2'b11, 4); tick();
        feed(150, 61, 2'b11, 4); tick();
        idle();
        check("t5_any_dec", 32'(gedaald), 32'd1);
        check("t5_any_eq", 32'(gelijk), 32'd1);
        check("t5_any_inc", 32'(gestegen), 32'd0);
        feed(100, 61, 2'b11, 4); tick();
        mode = 1'b1;
        idle();
        check("t5_all_flags", 32'({gedaald, gelijk, gestegen}), 32'd0);
        feed(50, 61, 2'b11, 4); tick();
        ch_enable = 2'b01;
        idle();
        check("t5_masked_dec", 32'(gedaald), 32'd1);

        // 6: coincident sample opens the next window; mid-window reset
        ch_enable = 2'b11; mode = 1'b0;
        cyc(1'b1, 2'b01, pack(70, 0));
        feed(70, 0, 2'b01, 3); tick();
        check("t6_coincident", 32'(trend[1:0]), 32'd3);
        feed(70, 70, 2'b11, 2);
        reset = 1'b0;
        idle();
        check("t6_primed_clr", 32'(primed), 32'd0);
        reset = 1'b1;
        feed(70, 70, 2'b11, 4); tick();
        check("t6_after_rst", 32'(trend), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < NCH; c++) base[c] = $urandom_range(0, 250);
        for (int i = 0; i < 4000; i++) begin
            logic             ev;
            logic [NCH-1:0]   v;
            int               d[NCH];
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 49) == 0) base[c] = $urandom_range(0, 250);
                d[c] = base[c] + $urandom_range(0, 5);
                if (d[c] > 255) d[c] = 255;
                v[c] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 19) == 0) begin
                ch_enable = NCH'($urandom);
                mode      = 1'($urandom);
            end
            reset = ($urandom_range(0, 299) != 0);
            ev    = ($urandom_range(0, 5) == 0);
            cyc(ev, v, pack(d[0], d[1]));
        end
        reset = 1'b1;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
